wb_arbiter2: RTL and testbench

- Wishbone B4 pipelined 2:1 arbiter directly downstream of the Ibex Wishbone wrapper: port m0 takes the instruction bus, port m1 the data bus, and one shared slave port drives the memory/peripheral interconnect.
- Round-robin arbitration with grant held for a whole bus cycle (cyc high).
- Tracks outstanding transfers so acks/errs are routed only to the owning master.

---
 rtl/wb_arbiter2.sv | 137 +++++++++++++
 tb/tb_wb_arbiter2.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 pipelined arbiter (m0 = instruction, m1 = data) with round-robin grant per bus cycle.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out a transfer the slave never answers.
module wb_arbiter2 #(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_cyc,
   input  logic            m0_stb,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_adr,
   input  logic [DW/8-1:0] m0_sel,
   input  logic [DW-1:0]   m0_dat_w,
   output logic [DW-1:0]   m0_dat_r,
   output logic            m0_ack,
   output logic            m0_err,
   output logic            m0_stall,
   input  logic            m1_cyc,
   input  logic            m1_stb,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_adr,
   input  logic [DW/8-1:0] m1_sel,
   input  logic [DW-1:0]   m1_dat_w,
   output logic [DW-1:0]   m1_dat_r,
   output logic            m1_ack,
   output logic            m1_err,
   output logic            m1_stall,
   output logic            s_cyc,
   output logic            s_stb,
   output logic            s_we,
   output logic [AW-1:0]   s_adr,
   output logic [DW/8-1:0] s_sel,
   output logic [DW-1:0]   s_dat_w,
   input  logic [DW-1:0]   s_dat_r,
   input  logic            s_ack,
   input  logic            s_err,
   input  logic            s_stall
);

   // state | meaning
   // IDLE  | no owner; slave sees no cycle, both masters stalled
   // GNT0  | m0 owns the slave port until it drops cyc
   // GNT1  | m1 owns the slave port until it drops cyc
   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   state_t        state;
   logic          ptr;
   logic [CW-1:0] count;

   logic gnt0, gnt1, granted;
   logic g_cyc, g_stb;
   logic full, busy;
   logic accept, retire, release_bus;
   logic timeout_hit;

   assign gnt0    = (state == GNT0);
   assign gnt1    = (state == GNT1);
   assign granted = gnt0 | gnt1;
   assign full    = (count == CW'(MAX_OUTSTANDING));
   assign busy    = (count != '0);
   assign g_cyc   = (gnt0 & m0_cyc) | (gnt1 & m1_cyc);
   assign g_stb   = (gnt0 & m0_stb) | (gnt1 & m1_stb);

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wd_cnt;
   logic          wd_run;

   assign wd_run      = granted & busy & ~s_ack & ~s_err;
   assign timeout_hit = wd_run & (wd_cnt == '0);

   // Down-counter reloads whenever the slave answers or nothing is outstanding.
   always_ff @(posedge clk) begin
      if (rst || !wd_run)
         wd_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (wd_cnt != '0)
         wd_cnt <= wd_cnt - 1'b1;
   end
`else
   assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   assign s_cyc   = g_cyc & ~timeout_hit;
   assign s_stb   = s_cyc & g_stb & ~full;
   assign s_we    = gnt1 ? m1_we    : m0_we;
   assign s_adr   = gnt1 ? m1_adr   : m0_adr;
   assign s_sel   = gnt1 ? m1_sel   : m0_sel;
   assign s_dat_w = gnt1 ? m1_dat_w : m0_dat_w;

   assign m0_dat_r = s_dat_r;
   assign m1_dat_r = s_dat_r;
   assign m0_stall = gnt0 ? (s_stall | full) : 1'b1;
   assign m1_stall = gnt1 ? (s_stall | full) : 1'b1;
   assign m0_ack   = gnt0 & s_ack & busy;
   assign m1_ack   = gnt1 & s_ack & busy;
   assign m0_err   = gnt0 & ((s_err & busy) | timeout_hit);
   assign m1_err   = gnt1 & ((s_err & busy) | timeout_hit);

   assign accept      = s_stb & ~s_stall;
   assign retire      = (s_ack | s_err) & busy;
   assign release_bus = granted & (~g_cyc | timeout_hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               if (m0_cyc && (!m1_cyc || !ptr))
                  state <= GNT0;
               else if (m1_cyc)
                  state <= GNT1;
            end
            GNT0, GNT1: begin
               // Releasing the bus abandons anything in flight; late acks are then dropped.
               if (release_bus) begin
                  state <= IDLE;
                  ptr   <= gnt0;
                  count <= '0;
               end else begin
                  count <= count + CW'(accept) - CW'(retire);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus a randomized run scored against queue-based slave/master models.
module tb_wb_arbiter2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SW   = DW / 8;
   localparam int MAXO = 4;
   localparam int TMO  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [AW-1:0] m0_adr, m1_adr, s_adr;
   logic [SW-1:0] m0_sel, m1_sel, s_sel;
   logic [DW-1:0] m0_dat_w, m1_dat_w, s_dat_w;
   logic [DW-1:0] m0_dat_r, m1_dat_r, s_dat_r;
   logic          m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
   logic          s_cyc, s_stb, s_we, s_ack, s_err, s_stall;

   int checks = 0;
   int errors = 0;

   wb_arbiter2 #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
      .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
      .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel), .s_dat_w(s_dat_w),
      .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_w = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_w = '0;
      s_dat_r = '0; s_ack = 0; s_err = 0; s_stall = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      next_cycle();
      next_cycle();
      rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      m0_cyc = 1;
      m1_cyc = 1;
      next_cycle();
      sample();
      checks++;
      if ({s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, m0_stall, m1_stall} !== 8'b0000_0011) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000011",
                  {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, m0_stall, m1_stall});
      end
      next_cycle();
      idle_inputs();
      rst = 0;
      next_cycle();
   endtask

   task automatic test_single();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_we = 0; m0_sel = 4'hF;
      sample();
      checks++;
      if ({m0_stall, s_stb} !== 2'b10) begin
         errors++; $display("FAIL single_c0 stall/stb: got %b expected 10", {m0_stall, s_stb});
      end
      next_cycle(); sample();
      checks++;
      if ({s_stb, m0_stall, s_adr} !== {2'b10, 32'h100}) begin
         errors++; $display("FAIL single_c1 stb/stall/adr: got %b %b %h expected 1 0 100", s_stb, m0_stall, s_adr);
      end
      next_cycle(); m0_stb = 0; sample();
      checks++;
      if ({m0_ack, m1_ack} !== 2'b00) begin
         errors++; $display("FAIL single_c2 acks: got %b expected 00", {m0_ack, m1_ack});
      end
      next_cycle(); s_ack = 1; s_dat_r = 32'hDEADBEEF; sample();
      checks++;
      if ({m0_ack, m1_ack, m0_dat_r} !== {2'b10, 32'hDEADBEEF}) begin
         errors++; $display("FAIL single_c3 ack/data: got %b %b %h expected 1 0 deadbeef", m0_ack, m1_ack, m0_dat_r);
      end
      next_cycle(); s_ack = 0; m0_cyc = 0; sample();
      checks++;
      if ({m0_ack, m1_ack} !== 2'b00) begin
         errors++; $display("FAIL single_c4 acks: got %b expected 00", {m0_ack, m1_ack});
      end
      next_cycle();
   endtask

   task automatic test_contention();
      // {m0_cyc, m1_cyc} per cycle, and required {s_cyc, m0_stall, m1_stall}
      logic [1:0] req [14] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                               2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
      logic [2:0] exp [14] = '{3'b011, 3'b101, 3'b001, 3'b011, 3'b110, 3'b010, 3'b011,
                               3'b011, 3'b101, 3'b001, 3'b011, 3'b110, 3'b010, 3'b011};
      do_reset();
      for (int i = 0; i < 14; i++) begin
         {m0_cyc, m1_cyc} = req[i];
         sample();
         checks++;
         if ({s_cyc, m0_stall, m1_stall} !== exp[i]) begin
            errors++;
            $display("FAIL contention_c%0d cyc/stall0/stall1: got %b expected %b", i, {s_cyc, m0_stall, m1_stall}, exp[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_full();
      int   issued = 0;
      int   acked = 0;
      int   pend;
      logic ack;
      logic exp_stall;
      do_reset();
      m1_cyc = 1;
      for (int c = 0; c < 40; c++) begin
         pend    = issued - acked;
         m1_stb  = (issued < 6);
         m1_adr  = 32'h2000 + 32'(issued * 4);
         ack     = (c >= 11) && (pend > 0);
         s_ack   = ack;
         s_dat_r = 32'hC0DE0000 + 32'(acked);
         sample();
         exp_stall = (c == 0) || (pend >= MAXO);
         checks++;
         if (m1_stall !== exp_stall) begin
            errors++; $display("FAIL full_stall_c%0d: got %b expected %b", c, m1_stall, exp_stall);
         end
         checks++;
         if ({m0_ack, m1_ack} !== {1'b0, ack}) begin
            errors++; $display("FAIL full_ack_c%0d: got %b expected %b", c, {m0_ack, m1_ack}, {1'b0, ack});
         end
         if (c == 10) begin
            checks++;
            if (issued !== 4) begin
               errors++; $display("FAIL full_accepted_before_acks: got %0d expected 4", issued);
            end
         end
         if (m1_stb && !m1_stall) issued++;
         if (ack) acked++;
         next_cycle();
      end
      checks++;
      if (issued !== 6 || acked !== 6) begin
         errors++; $display("FAIL full_totals: got accepted=%0d acked=%0d expected 6 6", issued, acked);
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_abort();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
      next_cycle(); sample();
      checks++;
      if ({s_stb, m0_stall} !== 2'b10) begin
         errors++; $display("FAIL abort_first_stb: got %b expected 10", {s_stb, m0_stall});
      end
      next_cycle(); m0_adr = 32'h304;
      next_cycle(); m0_cyc = 0; m0_stb = 0; m1_cyc = 1; sample();
      checks++;
      if ({s_cyc, s_stb} !== 2'b00) begin
         errors++; $display("FAIL abort_s_cyc: got %b expected 00", {s_cyc, s_stb});
      end
      next_cycle(); s_ack = 1; sample();
      checks++;
      if ({m0_ack, m1_ack, m1_stall} !== 3'b001) begin
         errors++; $display("FAIL abort_late_ack_idle: got %b expected 001", {m0_ack, m1_ack, m1_stall});
      end
      next_cycle(); sample();
      checks++;
      if ({m0_ack, m1_ack, m1_stall} !== 3'b000) begin
         errors++; $display("FAIL abort_late_ack_m1: got %b expected 000", {m0_ack, m1_ack, m1_stall});
      end
      next_cycle(); idle_inputs();
      next_cycle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500;
      next_cycle(); next_cycle(); next_cycle();
      next_cycle(); m1_stb = 0; rst = 1;
      next_cycle(); rst = 0; sample();
      checks++;
      if ({s_cyc, m0_stall, m1_stall} !== 3'b011) begin
         errors++; $display("FAIL reset_mid_outputs: got %b expected 011", {s_cyc, m0_stall, m1_stall});
      end
      next_cycle(); s_ack = 1; sample();
      checks++;
      if ({m1_ack, m1_stall} !== 2'b00) begin
         errors++; $display("FAIL reset_mid_count_cleared: got ack/stall %b expected 00", {m1_ack, m1_stall});
      end
      next_cycle(); s_ack = 0; m1_stb = 1; sample();
      checks++;
      if (s_stb !== 1'b1) begin
         errors++; $display("FAIL reset_mid_new_stb: got %b expected 1", s_stb);
      end
      next_cycle(); m1_stb = 0; s_ack = 1; sample();
      checks++;
      if (m1_ack !== 1'b1) begin
         errors++; $display("FAIL reset_mid_new_ack: got %b expected 1", m1_ack);
      end
      next_cycle(); idle_inputs();
      next_cycle();
   endtask

`ifdef WB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int   err_cnt = 0;
      logic exp_err;
      do_reset();
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
      next_cycle();
      next_cycle(); m1_stb = 0;
      for (int k = 2; k <= 10; k++) begin
         sample();
         exp_err = (k == 9);
         checks++;
         if ({m1_err, m0_err} !== {exp_err, 1'b0}) begin
            errors++; $display("FAIL timeout_err_c%0d: got %b expected %b", k, {m1_err, m0_err}, {exp_err, 1'b0});
         end
         if (m1_err) err_cnt++;
         if (k == 9) begin
            checks++;
            if (s_cyc !== 1'b0) begin
               errors++; $display("FAIL timeout_s_cyc: got %b expected 0", s_cyc);
            end
         end
         if (k == 10) begin
            checks++;
            if ({s_cyc, m1_stall} !== 2'b01) begin
               errors++; $display("FAIL timeout_idle: got %b expected 01", {s_cyc, m1_stall});
            end
         end
         next_cycle();
      end
      checks++;
      if (err_cnt !== 1) begin
         errors++; $display("FAIL timeout_pulse_count: got %0d expected 1", err_cnt);
      end
      idle_inputs();
      next_cycle();
   endtask
`endif

   task automatic test_random();
      logic [31:0] q_s[$];
      logic [31:0] q_m0[$];
      logic [31:0] q_m1[$];
      bit          active[2];
      int          n_left[2];
      int          seq[2];
      int          wait_run = 0;
      int          total = 0;
      int          size_before;
      logic        ack_now, err_now, acc0, acc1, acc_s;
      logic [31:0] head;
      logic [3:0]  exp_resp;
      logic [AW+SW+DW:0] exp_fwd;
      do_reset();
      for (int x = 0; x < 2; x++) begin active[x] = 0; n_left[x] = 0; seq[x] = 0; end
      for (int c = 0; c < 1500; c++) begin
         for (int x = 0; x < 2; x++) begin
            if (!active[x]) begin
               if ($urandom_range(3) == 0) begin active[x] = 1; n_left[x] = $urandom_range(6, 1); end
            end else if (n_left[x] == 0 && (x == 0 ? q_m0.size() == 0 : q_m1.size() == 0)) begin
               active[x] = 0;
            end
         end
         m0_cyc = active[0]; m0_stb = active[0] && n_left[0] > 0 && $urandom_range(3) != 0;
         m0_adr = {16'h0000, 16'(seq[0])}; m0_we = 1'($urandom); m0_sel = 4'($urandom); m0_dat_w = $urandom;
         m1_cyc = active[1]; m1_stb = active[1] && n_left[1] > 0 && $urandom_range(3) != 0;
         m1_adr = {16'h8000, 16'(seq[1])}; m1_we = 1'($urandom); m1_sel = 4'($urandom); m1_dat_w = $urandom;
         head    = (q_s.size() > 0) ? q_s[0] : 32'h0;
         ack_now = (q_s.size() > 0) && (wait_run >= 3 || $urandom_range(1) == 1);
         err_now = ack_now && ($urandom_range(7) == 0);
         s_ack   = ack_now && !err_now;
         s_err   = err_now;
         s_dat_r = ack_now ? (head ^ 32'h5A5AA5A5) : $urandom;
         s_stall = ($urandom_range(3) == 0);
         sample();
         size_before = q_s.size();
         acc0  = m0_cyc & m0_stb & ~m0_stall;
         acc1  = m1_cyc & m1_stb & ~m1_stall;
         acc_s = s_cyc & s_stb & ~s_stall;
         checks++;
         if ({acc0 & acc1, acc_s} !== {1'b0, acc0 | acc1}) begin
            errors++; $display("FAIL rand_accept_c%0d: acc0=%b acc1=%b slave=%b", c, acc0, acc1, acc_s);
         end
         if (size_before == MAXO) begin
            checks++;
            if (s_stb !== 1'b0) begin
               errors++; $display("FAIL rand_full_c%0d: s_stb got %b expected 0 with %0d outstanding", c, s_stb, size_before);
            end
         end
         if (acc_s) begin
            exp_fwd = acc1 ? {m1_we, m1_adr, m1_sel, m1_dat_w} : {m0_we, m0_adr, m0_sel, m0_dat_w};
            checks++;
            if ({s_we, s_adr, s_sel, s_dat_w} !== exp_fwd) begin
               errors++; $display("FAIL rand_fwd_c%0d: got %h expected %h", c, {s_we, s_adr, s_sel, s_dat_w}, exp_fwd);
            end
         end
         exp_resp = !ack_now ? 4'b0000 : (head[31] ? {2'b00, s_ack, s_err} : {s_ack, s_err, 2'b00});
         checks++;
         if ({m0_ack, m0_err, m1_ack, m1_err} !== exp_resp) begin
            errors++; $display("FAIL rand_resp_c%0d: got %b expected %b", c, {m0_ack, m0_err, m1_ack, m1_err}, exp_resp);
         end
         if (ack_now) begin
            checks++;
            if ((head[31] ? m1_dat_r : m0_dat_r) !== (head ^ 32'h5A5AA5A5)) begin
               errors++; $display("FAIL rand_data_c%0d: got %h expected %h", c, head[31] ? m1_dat_r : m0_dat_r, head ^ 32'h5A5AA5A5);
            end
            void'(q_s.pop_front());
            if (head[31]) void'(q_m1.pop_front()); else void'(q_m0.pop_front());
            wait_run = 0;
            total++;
         end else if (size_before > 0) begin
            wait_run++;
         end
         if (acc_s) q_s.push_back(s_adr);
         if (acc0) begin q_m0.push_back(m0_adr); n_left[0]--; seq[0]++; end
         if (acc1) begin q_m1.push_back(m1_adr); n_left[1]--; seq[1]++; end
         next_cycle();
      end
      checks++;
      if (total < 100) begin
         errors++; $display("FAIL rand_progress: got %0d completed transfers expected at least 100", total);
      end
      idle_inputs();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_full();
      test_abort();
      test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not complete");
      $fatal(1, "time limit");
   end
endmodule
